// File: rtl/eq_pkg.sv
// Shared equalizer constants and the saturation helper used by the band front end.
package eq_pkg;
   localparam int SAMPLE_BITS       = 16;
   localparam int GAIN_BITS         = 16;
   localparam int GAIN_FRAC         = 14;
   localparam int NUMBER_OF_FILTERS = 8;
   localparam int GAIN_UNITY        = 1 << GAIN_FRAC;

   // Clamp a wide signed value to the range of a signed field of the given width.
   function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                     input int width);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (value > hi)      sat_signed = hi;
      else if (value < lo) sat_signed = lo;
      else                 sat_signed = value;
   endfunction
endpackage

// File: rtl/band_gain_sat.sv
// One lane: signed sample times Q-format gain, floor shift, saturate to sample width.
module band_gain_sat
   import eq_pkg::*;
#(
   parameter int SB = SAMPLE_BITS,
   parameter int GB = GAIN_BITS,
   parameter int GF = GAIN_FRAC
) (
   input  logic signed [SB-1:0] sample,
   input  logic signed [GB-1:0] gain,
   output logic        [SB-1:0] scaled
);
   logic signed [SB+GB-1:0] prod;
   logic signed [SB+GB-1:0] shifted;

   assign prod    = sample * gain;
   assign shifted = prod >>> GF;
   assign scaled  = SB'(sat_signed(64'(shifted), SB));
endmodule

// File: rtl/band_distributor.sv
// Fans one audio sample out to every band filter, scaled per band, with an
// independent valid/ready handshake per lane.
module band_distributor
   import eq_pkg::*;
#(
   parameter int SAMPLE_BITS_P       = SAMPLE_BITS,
   parameter int NUMBER_OF_FILTERS_P = NUMBER_OF_FILTERS,
   parameter int GAIN_BITS_P         = GAIN_BITS,
   parameter int GAIN_FRAC_P         = GAIN_FRAC
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic [SAMPLE_BITS_P-1:0]                      in_sample,
   input  logic                                          in_valid,
   output logic                                          in_ready,
   input  logic [NUMBER_OF_FILTERS_P*GAIN_BITS_P-1:0]    band_gains,
   output logic [NUMBER_OF_FILTERS_P*SAMPLE_BITS_P-1:0]  filter_ins,
   output logic [NUMBER_OF_FILTERS_P-1:0]                filter_valid,
   input  logic [NUMBER_OF_FILTERS_P-1:0]                filter_ready,
   output logic [31:0]                                   sample_count
);
   localparam int N  = NUMBER_OF_FILTERS_P;
   localparam int SB = SAMPLE_BITS_P;
   localparam int GB = GAIN_BITS_P;

   logic [N-1:0]    pending_q, pending_d;
   logic [N*SB-1:0] lanes_q, lanes_d, scaled;
   logic [31:0]     count_q, count_d;
   logic            accept;

   for (genvar g = 0; g < N; g++) begin : g_lane
      band_gain_sat #(.SB(SB), .GB(GB), .GF(GAIN_FRAC_P)) u_lane (
         .sample (in_sample),
         .gain   (band_gains[g*GB +: GB]),
         .scaled (scaled[g*SB +: SB])
      );
   end

   // A new sample may enter once every still-pending lane is being drained this cycle.
   assign in_ready = rst & ((pending_q & ~filter_ready) == '0);
   assign accept   = in_valid & in_ready;

   always_comb begin
      pending_d = pending_q & ~filter_ready;
      lanes_d   = lanes_q;
      count_d   = count_q;
      if (accept) begin
         pending_d = '1;
         lanes_d   = scaled;
         count_d   = count_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pending_q <= '0;
         lanes_q   <= '0;
         count_q   <= '0;
      end else begin
         pending_q <= pending_d;
         lanes_q   <= lanes_d;
         count_q   <= count_d;
      end
   end

   assign filter_valid = pending_q;
   assign filter_ins   = lanes_q;
   assign sample_count = count_q;
endmodule

// File: tb/tb_band_distributor.sv
// Scoreboard bench for band_distributor: per-lane expected-value queues fed on
// accept, drained by a monitor on every lane transfer.
module tb_band_distributor;
   localparam int N  = 8;
   localparam int SB = 16;
   localparam int GB = 16;

   logic            clk = 0;
   logic            rst = 0;
   logic [SB-1:0]   in_sample = '0;
   logic            in_valid = 0;
   logic            in_ready;
   logic [N*GB-1:0] band_gains = '0;
   logic [N*SB-1:0] filter_ins;
   logic [N-1:0]    filter_valid;
   logic [N-1:0]    filter_ready = '0;
   logic [31:0]     sample_count;

   int compared = 0;
   int mismatched = 0;
   int lane_q[N][$];
   int exp_count = 0;
   int gains[N];

   band_distributor dut (
      .clk(clk), .rst(rst), .in_sample(in_sample), .in_valid(in_valid),
      .in_ready(in_ready), .band_gains(band_gains), .filter_ins(filter_ins),
      .filter_valid(filter_valid), .filter_ready(filter_ready),
      .sample_count(sample_count)
   );

   always #5 clk = ~clk;

   // Reference: exact product, floor division by 2^14, clamp to 16-bit signed.
   function automatic int ref_scale(input int s, input int g);
      longint p, q;
      p = longint'(s) * longint'(g);
      q = p / 16384;
      if (p < 0 && (p % 16384) != 0) q = q - 1;
      if (q > 32767)  q = 32767;
      if (q < -32768) q = -32768;
      return int'(q);
   endfunction

   function automatic bit all_drain_ok();
      for (int i = 0; i < N; i++)
         if (lane_q[i].size() != 0 && !filter_ready[i]) return 0;
      return 1;
   endfunction

   // Monitor: compare handshake state and pop data on each lane transfer.
   always @(negedge clk) begin
      logic exp_rdy;
      int   got;
      exp_rdy = rst && all_drain_ok();
      compared++;
      if (in_ready !== exp_rdy) begin
         mismatched++;
         $display("FAIL in_ready t=%0t got=%b exp=%b", $time, in_ready, exp_rdy);
      end
      compared++;
      if (sample_count !== 32'(exp_count)) begin
         mismatched++;
         $display("FAIL sample_count t=%0t got=%0d exp=%0d", $time, sample_count, exp_count);
      end
      for (int i = 0; i < N; i++) begin
         compared++;
         if (filter_valid[i] !== (lane_q[i].size() != 0)) begin
            mismatched++;
            $display("FAIL valid lane%0d t=%0t got=%b exp=%b", i, $time,
                     filter_valid[i], lane_q[i].size() != 0);
         end
         if (filter_valid[i] && filter_ready[i] && lane_q[i].size() != 0) begin
            got = int'($signed(filter_ins[i*SB +: SB]));
            compared++;
            if (got != lane_q[i][0]) begin
               mismatched++;
               $display("FAIL data lane%0d t=%0t got=%0d exp=%0d", i, $time, got, lane_q[i][0]);
            end
            void'(lane_q[i].pop_front());
         end
      end
   end

   // One clock of stimulus; after the monitor drains, decide accept/reset effects.
   task automatic cycle(input bit r, input bit v, input int s, input logic [N-1:0] rdy);
      @(posedge clk);
      #1;
      rst = r;
      in_valid = v;
      in_sample = SB'(s);
      filter_ready = rdy;
      for (int i = 0; i < N; i++) band_gains[i*GB +: GB] = GB'(gains[i]);
      @(negedge clk);
      #1;
      if (!rst) begin
         for (int i = 0; i < N; i++) lane_q[i].delete();
         exp_count = 0;
      end else begin
         bit empty;
         empty = 1;
         for (int i = 0; i < N; i++) if (lane_q[i].size() != 0) empty = 0;
         if (in_valid && empty) begin
            for (int i = 0; i < N; i++)
               lane_q[i].push_back(ref_scale(int'($signed(in_sample)), gains[i]));
            exp_count++;
         end
      end
   endtask

   task automatic set_gains(input int g);
      for (int i = 0; i < N; i++) gains[i] = g;
   endtask

   initial begin
      set_gains(16384);
      repeat (3) cycle(0, 0, 0, '1);
      // unity gain
      cycle(1, 1, 1000, '1);
      cycle(1, 0, 0, '1);
      cycle(1, 0, 0, '1);
      // saturation both ways
      set_gains(32767);
      cycle(1, 1, 30000, '1);
      cycle(1, 1, -30000, '1);
      cycle(1, 0, 0, '1);
      // floor toward -inf and zero gain, mixed across lanes
      for (int i = 0; i < N; i++) gains[i] = (i % 2) ? 0 : 8192;
      cycle(1, 1, -1, '1);
      cycle(1, 1, -3, '1);
      cycle(1, 0, 0, '1);
      // lane 3 stalls for 5 clocks while input keeps offering a sample
      set_gains(16384);
      cycle(1, 1, 111, '1);
      for (int k = 0; k < 5; k++) cycle(1, 1, 222, 8'hF7);
      cycle(1, 1, 222, '1);
      cycle(1, 0, 0, '1);
      cycle(1, 0, 0, '1);
      // continuous stream from a fresh count
      cycle(0, 0, 0, '1);
      for (int k = 0; k < 100; k++) begin
         for (int i = 0; i < N; i++) gains[i] = $urandom_range(0, 65535) - 32768;
         cycle(1, 1, int'($urandom_range(0, 65535)) - 32768, '1);
      end
      cycle(1, 0, 0, '1);
      compared++;
      if (sample_count !== 32'd100) begin
         mismatched++;
         $display("FAIL stream_count got=%0d exp=100", sample_count);
      end
      // reset while lanes pending
      cycle(1, 1, 500, '0);
      cycle(1, 0, 0, '0);
      cycle(0, 0, 0, '0);
      cycle(1, 1, 77, '1);
      cycle(1, 0, 0, '1);
      // random traffic with stalls and gain changes while data is pending
      for (int k = 0; k < 600; k++) begin
         int s;
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 3) == 0) gains[i] = $urandom_range(0, 65535) - 32768;
         case ($urandom_range(0, 3))
            0: s = 32767;
            1: s = -32768;
            default: s = int'($urandom_range(0, 65535)) - 32768;
         endcase
         cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0), s,
               N'($urandom) | N'($urandom));
      end
      for (int k = 0; k < 3; k++) cycle(1, 0, 0, '1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
